fetch_ctrl: RTL and testbench

Fetch-stage controller that sequences the PC update datapath against a variable-latency instruction memory. It owns the single-entry fetch buffer feeding decode. It decides each cycle whether the PC holds, advances by 2, or takes a branch redirect, and it stops fetch permanently on HLT. It drives the PC updater's hold and branch-enable inputs and never fetches down a wrong path.

---
 rtl/fetch_ctrl.sv | 101 ++++++++++
 tb/tb_fetch_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch-stage controller with single-entry fetch buffer and HLT stop
module fetch_ctrl #(
    parameter logic [3:0] HLT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ready,
    input  logic [15:0] imem_data,
    input  logic        stall_in,
    input  logic        br_taken,
    output logic        pc_hold,
    output logic        pc_branch_en,
    output logic [15:0] instr_out,
    output logic        instr_valid,
    output logic        halted,
    output logic [15:0] bubble_cnt
);

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } stateT;

    stateT       state;
    stateT       stateNext;
    logic        instrValidQ;
    logic [15:0] instrOutQ;
    logic [15:0] bubbleCntQ;
    logic        consume;
    logic        redirect;
    logic        fire;
    logic        isHlt;

    assign isHlt       = (imem_data[15:12] == HLT_OPCODE);
    assign instr_out   = instrOutQ;
    assign instr_valid = instrValidQ;
    assign halted      = (state == HALT);
    assign bubble_cnt  = bubbleCntQ;

    // State register; HALT is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= stateNext;
        end
    end

    // Request gating, PC control and next state; everything is quiet while in reset
    always_comb begin
        stateNext    = state;
        imem_req     = 1'b0;
        pc_hold      = 1'b1;
        pc_branch_en = 1'b0;
        consume      = instrValidQ & ~stall_in;
        redirect     = 1'b0;
        fire         = 1'b0;
        if (!rst && state == FETCH) begin
            // A taken branch leaving the buffer kills any in-flight fetch of the fall-through path
            redirect = consume & br_taken;
            imem_req = ~redirect & (~instrValidQ | ~stall_in);
            fire     = imem_req & imem_ready;
            if (redirect) begin
                pc_hold      = 1'b0;
                pc_branch_en = 1'b1;
            end else if (fire) begin
                if (isHlt) begin
                    stateNext = HALT;
                end else begin
                    pc_hold = 1'b0;
                end
            end
        end
    end

    // Fetch buffer: load on fire, empty on redirect or plain consume
    always_ff @(posedge clk) begin
        if (rst) begin
            instrValidQ <= 1'b0;
            instrOutQ   <= 16'h0000;
        end else if (redirect) begin
            instrValidQ <= 1'b0;
        end else if (fire) begin
            instrOutQ   <= imem_data;
            instrValidQ <= 1'b1;
        end else if (consume) begin
            instrValidQ <= 1'b0;
        end
    end

    // Saturating count of empty-buffer cycles while fetching
    always_ff @(posedge clk) begin
        if (rst) begin
            bubbleCntQ <= 16'h0000;
        end else if (state == FETCH && !instrValidQ && bubbleCntQ != 16'hFFFF) begin
            bubbleCntQ <= bubbleCntQ + 16'h0001;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic        imem_ready;
    logic [15:0] imem_data;
    logic        stall_in;
    logic        br_taken;
    logic        pc_hold;
    logic        pc_branch_en;
    logic [15:0] instr_out;
    logic        instr_valid;
    logic        halted;
    logic [15:0] bubble_cnt;

    int checks = 0;
    int errors = 0;

    fetch_ctrl #(.HLT_OPCODE(4'hF)) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_data   (imem_data),
        .stall_in    (stall_in),
        .br_taken    (br_taken),
        .pc_hold     (pc_hold),
        .pc_branch_en(pc_branch_en),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .halted      (halted),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [15:0] d, input logic st, input logic br);
        rst        = r;
        imem_ready = rdy;
        imem_data  = d;
        stall_in   = st;
        br_taken   = br;
    endtask

    // Check combinational outputs mid-cycle (negedge)
    task automatic checkComb(input string tag, input logic req, input logic hold, input logic ben);
        @(negedge clk);
        checkEq({tag, ".req"}, {15'd0, imem_req}, {15'd0, req});
        checkEq({tag, ".hold"}, {15'd0, pc_hold}, {15'd0, hold});
        checkEq({tag, ".ben"}, {15'd0, pc_branch_en}, {15'd0, ben});
    endtask

    // Advance through the rising edge and check registered state shortly after it
    task automatic checkRegs(input string tag, input logic v, input logic [15:0] o, input logic h, input logic [15:0] b);
        @(posedge clk);
        #1;
        checkEq({tag, ".valid"}, {15'd0, instr_valid}, {15'd0, v});
        checkEq({tag, ".out"}, instr_out, o);
        checkEq({tag, ".halted"}, {15'd0, halted}, {15'd0, h});
        checkEq({tag, ".bubble"}, bubble_cnt, b);
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        // reset cycle outputs and reset values
        checkComb("rst", 1'b0, 1'b1, 1'b0);
        checkRegs("rst", 1'b0, 16'h0000, 1'b0, 16'h0000);

        // sequential fetch, 1-cycle memory; consume and fire overlap
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        checkComb("seq1", 1'b1, 1'b0, 1'b0);
        checkRegs("seq1", 1'b1, 16'h1234, 1'b0, 16'h0001);
        drive(1'b0, 1'b1, 16'h2345, 1'b0, 1'b0);
        checkComb("seq2", 1'b1, 1'b0, 1'b0);
        checkRegs("seq2", 1'b1, 16'h2345, 1'b0, 16'h0001);
        drive(1'b0, 1'b1, 16'h3456, 1'b0, 1'b0);
        checkComb("seq3", 1'b1, 1'b0, 1'b0);
        checkRegs("seq3", 1'b1, 16'h3456, 1'b0, 16'h0001);

        // drain 3456 with memory not ready
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkComb("drain", 1'b1, 1'b1, 1'b0);
        checkRegs("drain", 1'b0, 16'h3456, 1'b0, 16'h0001);

        // 3-cycle latency fetch
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkComb("lat.w1", 1'b1, 1'b1, 1'b0);
        checkRegs("lat.w1", 1'b0, 16'h3456, 1'b0, 16'h0002);
        checkComb("lat.w2", 1'b1, 1'b1, 1'b0);
        checkRegs("lat.w2", 1'b0, 16'h3456, 1'b0, 16'h0003);
        drive(1'b0, 1'b1, 16'h4567, 1'b0, 1'b0);
        checkComb("lat.fire", 1'b1, 1'b0, 1'b0);
        checkRegs("lat.fire", 1'b1, 16'h4567, 1'b0, 16'h0004);

        // taken branch while a request would be pending; ready in the redirect cycle is ignored
        drive(1'b0, 1'b1, 16'h1111, 1'b0, 1'b1);
        checkComb("br.redir", 1'b0, 1'b0, 1'b1);
        checkRegs("br.redir", 1'b0, 16'h4567, 1'b0, 16'h0004);
        drive(1'b0, 1'b1, 16'h5678, 1'b0, 1'b0);
        checkComb("br.target", 1'b1, 1'b0, 1'b0);
        checkRegs("br.target", 1'b1, 16'h5678, 1'b0, 16'h0005);

        // stall with full buffer and pending branch for 4 cycles
        drive(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkComb("stall", 1'b0, 1'b1, 1'b0);
            checkRegs("stall", 1'b1, 16'h5678, 1'b0, 16'h0005);
        end
        drive(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
        checkComb("stall.redir", 1'b0, 1'b0, 1'b1);
        checkRegs("stall.redir", 1'b0, 16'h5678, 1'b0, 16'h0005);

        // HLT fetch
        drive(1'b0, 1'b1, 16'hF000, 1'b0, 1'b0);
        checkComb("hlt.fire", 1'b1, 1'b1, 1'b0);
        checkRegs("hlt.fire", 1'b1, 16'hF000, 1'b1, 16'h0006);
        drive(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0);
        checkComb("hlt.hold", 1'b0, 1'b1, 1'b0);
        checkRegs("hlt.hold", 1'b1, 16'hF000, 1'b1, 16'h0006);
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
        checkComb("hlt.drain", 1'b0, 1'b1, 1'b0);
        checkRegs("hlt.drain", 1'b0, 16'hF000, 1'b1, 16'h0006);
        drive(1'b0, 1'b1, 16'h1234, 1'b0, 1'b0);
        checkComb("hlt.idle", 1'b0, 1'b1, 1'b0);
        checkRegs("hlt.idle", 1'b0, 16'hF000, 1'b1, 16'h0006);

        // leave HALT, start a slow fetch, reset mid-request
        drive(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkRegs("rst2", 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkComb("pend.w1", 1'b1, 1'b1, 1'b0);
        checkRegs("pend.w1", 1'b0, 16'h0000, 1'b0, 16'h0001);
        drive(1'b1, 1'b1, 16'h2222, 1'b0, 1'b0);
        checkComb("pend.rst", 1'b0, 1'b1, 1'b0);
        checkRegs("pend.rst", 1'b0, 16'h0000, 1'b0, 16'h0000);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkComb("pend.after", 1'b1, 1'b1, 1'b0);
        checkRegs("pend.after", 1'b0, 16'h0000, 1'b0, 16'h0001);

        // saturation: idle until FFFE, then 3 more cycles
        repeat (65533) @(posedge clk);
        #1;
        checkEq("sat.fffe", bubble_cnt, 16'hFFFE);
        repeat (3) @(posedge clk);
        #1;
        checkEq("sat.ffff", bubble_cnt, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
